// File: rtl/pong_draw_sched.sv
// pong_draw_sched: round-robin owner of the single VGA write port shared by the
// pong draw clients (0 = left paddle, 1 = right paddle, 2 = ball).
//
// Ports:
//   CLOCK_50     system clock, all state on rising edge
//   Resetn       asynchronous active-low reset
//   req          per-client request to own the VGA port (level)
//   done         per-client end-of-frame pulse, honoured only from the grantee
//   cli_x/y/color/plot  packed per-client pixel fields and write strobes
//   enable       one-hot grant, fed back to the clients' enable inputs
//   VGA_X/VGA_Y/VGA_COLOR/plot  registered pixel write to the VGA adapter
//   busy         high while a grant is held
//   timeout_err  sticky, set whenever the grant watchdog expires
module pong_draw_sched #(
  parameter int unsigned NCLI = 3,
  parameter int unsigned TO_W = 22
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [NCLI-1:0]   req,
  input  logic [NCLI-1:0]   done,
  input  logic [NCLI*8-1:0] cli_x,
  input  logic [NCLI*7-1:0] cli_y,
  input  logic [NCLI*3-1:0] cli_color,
  input  logic [NCLI-1:0]   cli_plot,
  output logic [NCLI-1:0]   enable,
  output logic [7:0]        VGA_X,
  output logic [6:0]        VGA_Y,
  output logic [2:0]        VGA_COLOR,
  output logic              plot,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned PW = (NCLI > 1) ? $clog2(NCLI) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NCLI-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            terr_d;

  // First requester at or after ptr, searching modulo NCLI.
  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NCLI; i++) begin
      cand = PW'((32'(ptr_q) + i) % NCLI);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Fields of the current grantee; all zero when nobody holds the grant.
  logic [7:0] g_x;
  logic [6:0] g_y;
  logic [2:0] g_color;
  logic       g_plot;

  always_comb begin
    g_x     = '0;
    g_y     = '0;
    g_color = '0;
    g_plot  = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      if (gnt_q[i]) begin
        g_x     = cli_x[i*8 +: 8];
        g_y     = cli_y[i*7 +: 7];
        g_color = cli_color[i*3 +: 3];
        g_plot  = cli_plot[i];
      end
    end
  end

  logic g_done, g_req, wd_max, grant_exit;

  // Masking with gnt_q is what makes done from a non-grantee invisible.
  assign g_done     = |(done & gnt_q);
  assign g_req      = |(req & gnt_q);
  assign wd_max     = &wd_q;
  assign grant_exit = g_done | ~g_req | wd_max;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    terr_d  = timeout_err;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = NCLI'(1) << sel_idx;
          gidx_d  = sel_idx;
          wd_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Saturate so the count can never wrap back to zero inside a grant.
        if (!wd_max) begin
          wd_d = wd_q + TO_W'(1);
        end
        if (grant_exit) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = (gidx_q == PW'(NCLI - 1)) ? '0 : gidx_q + PW'(1);
          if (wd_max) begin
            terr_d = 1'b1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      wd_q        <= '0;
      timeout_err <= 1'b0;
      VGA_X       <= '0;
      VGA_Y       <= '0;
      VGA_COLOR   <= '0;
      plot        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      timeout_err <= terr_d;
      // The exit cycle is still GRANT, so the grantee's final pixel lands here.
      if (state_q == GRANT) begin
        VGA_X     <= g_x;
        VGA_Y     <= g_y;
        VGA_COLOR <= g_color;
        plot      <= g_plot;
      end else begin
        plot <= 1'b0;
      end
    end
  end

  // Combinational so an asynchronous reset drops enable in the same cycle.
  assign enable = (state_q == GRANT) ? gnt_q : '0;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_pong_draw_sched.sv
// Directed self-checking bench for pong_draw_sched (NCLI = 3, TO_W = 4).
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_pong_draw_sched;

  logic        CLOCK_50;
  logic        Resetn;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [23:0] cli_x;
  logic [20:0] cli_y;
  logic [8:0]  cli_color;
  logic [2:0]  cli_plot;
  logic [2:0]  enable;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  pong_draw_sched #(
    .NCLI(3),
    .TO_W(4)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .req        (req),
    .done       (done),
    .cli_x      (cli_x),
    .cli_y      (cli_y),
    .cli_color  (cli_color),
    .cli_plot   (cli_plot),
    .enable     (enable),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOR  (VGA_COLOR),
    .plot       (plot),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    req       = '0;
    done      = '0;
    cli_x     = '0;
    cli_y     = '0;
    cli_color = '0;
    cli_plot  = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    Resetn = 1'b1;
  endtask

  // Bounded wait for any grant; callers compare enable afterwards.
  task automatic wait_enable(output int cyc);
    cyc = 0;
    while (enable === 3'b000 && cyc < 50) begin
      @(negedge CLOCK_50);
      cyc++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    Resetn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (enable !== 3'b000 || busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl enable=%b busy=%b plot=%b want 000/0/0", enable, busy, plot);
    end
    checks++;
    if (VGA_X !== 8'd0 || VGA_Y !== 7'd0 || VGA_COLOR !== 3'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data x=%0d y=%0d c=%0d terr=%b want 0/0/0/0",
               VGA_X, VGA_Y, VGA_COLOR, timeout_err);
    end
    Resetn = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (enable !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_noreq enable=%b want 000", enable);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    int cyc;
    apply_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp = 3'b001 << (k % 3);
      wait_enable(cyc);
      checks++;
      if (enable !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d enable=%b want %b", k, enable, exp);
      end
      if (k > 0) begin
        // GAP then IDLE, so the next grant shows two samples later.
        checks++;
        if (cyc != 2) begin
          errors++;
          $display("FAIL rr_gap%0d cycles=%0d want 2", k, cyc);
        end
      end
      for (int i = 1; i < 5; i++) begin
        @(negedge CLOCK_50);
        checks++;
        if (enable !== exp || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_hold%0d_%0d enable=%b busy=%b want %b/1", k, i, enable, busy, exp);
        end
      end
      done = exp;
      @(negedge CLOCK_50);
      done = '0;
      if (k == 3) req = '0;
      checks++;
      if (enable !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gapstate%0d enable=%b busy=%b want 000/0", k, enable, busy);
      end
    end
  endtask

  task automatic test_datapath();
    int cyc;
    apply_reset();
    cli_x[7:0]     = 8'd33;
    cli_x[15:8]    = 8'd80;
    cli_y[6:0]     = 7'd11;
    cli_y[13:7]    = 7'd59;
    cli_color[2:0] = 3'b010;
    cli_color[5:3] = 3'b111;
    cli_plot       = 3'b011;
    req            = 3'b010;
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b010 || plot !== 1'b0 || VGA_X !== 8'd0) begin
      errors++;
      $display("FAIL dp_grant enable=%b plot=%b x=%0d want 010/0/0", enable, plot, VGA_X);
    end
    @(negedge CLOCK_50);
    checks++;
    if (VGA_X !== 8'd80 || VGA_Y !== 7'd59 || VGA_COLOR !== 3'd7 || plot !== 1'b1) begin
      errors++;
      $display("FAIL dp_pixel x=%0d y=%0d c=%0d plot=%b want 80/59/7/1",
               VGA_X, VGA_Y, VGA_COLOR, plot);
    end
    cli_x[15:8] = 8'd81;
    cli_plot    = 3'b001;
    @(negedge CLOCK_50);
    checks++;
    if (VGA_X !== 8'd81 || plot !== 1'b0) begin
      errors++;
      $display("FAIL dp_other_plot x=%0d plot=%b want 81/0", VGA_X, plot);
    end
    req         = 3'b000;
    cli_plot    = 3'b010;
    cli_x[15:8] = 8'd82;
    @(negedge CLOCK_50);
    checks++;
    if (enable !== 3'b000 || plot !== 1'b1 || VGA_X !== 8'd82) begin
      errors++;
      $display("FAIL dp_last_pixel enable=%b plot=%b x=%0d want 000/1/82", enable, plot, VGA_X);
    end
    cli_plot    = 3'b111;
    cli_x[15:8] = 8'd90;
    @(negedge CLOCK_50);
    checks++;
    if (plot !== 1'b0 || VGA_X !== 8'd82) begin
      errors++;
      $display("FAIL dp_gap_hold plot=%b x=%0d want 0/82", plot, VGA_X);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int cyc;
    int n;
    apply_reset();
    req = 3'b100;
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b100 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_grant enable=%b terr=%b want 100/0", enable, timeout_err);
    end
    // Watchdog reads 0..15 across the grant and exits on the all-ones cycle.
    n = 1;
    while (enable === 3'b100 && n < 40) begin
      @(negedge CLOCK_50);
      if (enable === 3'b100) n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL to_length cycles=%0d want 16", n);
    end
    checks++;
    if (enable !== 3'b000 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_flag enable=%b terr=%b want 000/1", enable, timeout_err);
    end
    req = 3'b101;
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b001 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_next enable=%b terr=%b want 001/1", enable, timeout_err);
    end
    done = 3'b001;
    req  = 3'b000;
    @(negedge CLOCK_50);
    done = '0;
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky terr=%b want 1", timeout_err);
    end
    apply_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear terr=%b want 0", timeout_err);
    end
  endtask

  task automatic test_single_client();
    int cyc;
    apply_reset();
    req = 3'b001;
    for (int r = 0; r < 3; r++) begin
      wait_enable(cyc);
      checks++;
      if (enable !== 3'b001) begin
        errors++;
        $display("FAIL single_grant%0d enable=%b want 001", r, enable);
      end
      repeat (9) @(negedge CLOCK_50);
      checks++;
      if (enable !== 3'b001) begin
        errors++;
        $display("FAIL single_hold%0d enable=%b want 001", r, enable);
      end
      done = 3'b001;
      @(negedge CLOCK_50);
      done = '0;
      checks++;
      if (enable !== 3'b000) begin
        errors++;
        $display("FAIL single_gap%0d enable=%b want 000", r, enable);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    int cyc;
    apply_reset();
    req      = 3'b010;
    cli_plot = 3'b010;
    wait_enable(cyc);
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (enable !== 3'b010 || plot !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre enable=%b plot=%b want 010/1", enable, plot);
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if (enable !== 3'b000 || plot !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async enable=%b plot=%b busy=%b want 000/0/0", enable, plot, busy);
    end
    @(negedge CLOCK_50);
    checks++;
    if (enable !== 3'b000 || plot !== 1'b0) begin
      errors++;
      $display("FAIL rmid_held enable=%b plot=%b want 000/0", enable, plot);
    end
    req    = 3'b011;
    Resetn = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL rmid_noplot plot=%b want 0", plot);
    end
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b001) begin
      errors++;
      $display("FAIL rmid_first enable=%b want 001", enable);
    end
    clear_inputs();
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_same_cycle_exit();
    int cyc;
    apply_reset();
    req = 3'b010;
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b010) begin
      errors++;
      $display("FAIL same_grant enable=%b want 010", enable);
    end
    @(negedge CLOCK_50);
    done = 3'b010;
    req  = 3'b101;
    @(negedge CLOCK_50);
    done = '0;
    checks++;
    if (enable !== 3'b000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL same_exit enable=%b terr=%b want 000/0", enable, timeout_err);
    end
    wait_enable(cyc);
    checks++;
    if (enable !== 3'b100 || cyc != 2) begin
      errors++;
      $display("FAIL same_ptr enable=%b cycles=%0d want 100/2", enable, cyc);
    end
    clear_inputs();
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    Resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_datapath();
    test_timeout();
    test_single_client();
    test_reset_mid_grant();
    test_same_cycle_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_draw_sched.md
PONG_DRAW_SCHED -- requirements
Module: pong_draw_sched

Interface
REQ-001 Parameter NCLI, default 3, number of draw clients (0 = left paddle, 1 = right paddle, 2 = ball); fixed at 3 for this release.
REQ-002 Parameter TO_W, default 22, watchdog counter width; grant timeout = 2^TO_W - 1 cycles (set 4 for simulation).
REQ-003 CLOCK_50  in  1  system clock; all state on rising edge.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 req  in  3  per-client request to own the VGA write port; level.
REQ-006 done  in  3  per-client end-of-frame pulse (client's erase-complete "row" strobe); 1 cycle.
REQ-007 cli_x  in  24  packed client X, 8 bits per client, client 0 in [7:0].
REQ-008 cli_y  in  21  packed client Y, 7 bits per client.
REQ-009 cli_color  in  9  packed client colour, 3 bits per client.
REQ-010 cli_plot  in  3  per-client pixel write strobe.
REQ-011 enable  out  3  one-hot grant; drives the client's enable input.
REQ-012 VGA_X  out  8  registered pixel X to VGA adapter.
REQ-013 VGA_Y  out  7  registered pixel Y.
REQ-014 VGA_COLOR  out  3  registered pixel colour.
REQ-015 plot  out  1  registered write strobe to VGA adapter.
REQ-016 busy  out  1  high while a grant is held.
REQ-017 timeout_err  out  1  sticky flag, set on any watchdog expiry.

Function
REQ-018 FSM states SHALL be IDLE, GRANT, GAP.
REQ-019 IDLE: if req != 0, select the first requesting client at or after ptr (modulo 3), load one-hot gnt, clear watchdog, go to GRANT next cycle; else stay in IDLE.
REQ-020 GRANT: enable = gnt, busy = 1; watchdog increments every cycle.
REQ-021 GRANT exit on first of: done[g] = 1, req[g] = 0, or watchdog = all-ones; any exit goes to GAP.
REQ-022 Simultaneous exit conditions in one cycle SHALL be a single exit; timeout_err is set only if the watchdog is all-ones that cycle.
REQ-023 On GRANT exit, ptr SHALL become (g + 1) mod 3.
REQ-024 GAP: exactly one cycle; enable = 0, busy = 0; then IDLE.
REQ-025 Arbitration SHALL be round-robin; no client is granted twice while another client holds req continuously.
REQ-026 done or plot from a non-granted client SHALL be ignored.
REQ-027 In GRANT, VGA_X/VGA_Y/VGA_COLOR/plot SHALL register the granted client's fields one cycle later (latency 1).
REQ-028 In IDLE and GAP, plot SHALL register 0; VGA_X/VGA_Y/VGA_COLOR hold their last values.
REQ-029 The last plot of a grant (cycle of done) SHALL still reach the adapter, one cycle after exit.
REQ-030 enable SHALL never have more than one bit set; it is combinational from state and gnt.
REQ-031 Watchdog SHALL saturate at all-ones and never wrap inside a grant.
REQ-032 ptr SHALL wrap 2 -> 0.

Reset
REQ-033 Resetn low SHALL immediately force state IDLE, gnt 0, enable 0, ptr 0, watchdog 0, VGA_X 0, VGA_Y 0, VGA_COLOR 0, plot 0, busy 0, timeout_err 0.
REQ-034 Reset asserted mid-grant SHALL drop enable within the same cycle, with no further plot after deassertion until a new grant.
REQ-035 timeout_err SHALL clear only on reset.

Verification
REQ-036 Reset, req=3'b111, each client pulses done 5 cycles after its grant -> grant order 0,1,2,0; one GAP cycle between grants; enable one-hot throughout.
REQ-037 Granted client 1 with cli_x[15:8]=8'd80, cli_y[13:7]=7'd59, colour 3'b111, plot=1 -> next cycle VGA_X=80, VGA_Y=59, VGA_COLOR=7, plot=1; client 0 plot=1 concurrently is not forwarded.
REQ-038 TO_W=4, client 2 granted and never pulses done -> exit to GAP after 15 cycles, timeout_err=1, next grant goes to client 0.
REQ-039 req=3'b001 only, done every 10 cycles -> client 0 re-granted after each GAP; ptr skips idle clients 1 and 2.
REQ-040 Resetn pulsed low 3 cycles into a client 1 grant -> enable=0 and plot=0 during reset; first grant after release goes to client 0.
REQ-041 done[1]=1 and req[1]=0 in the same cycle -> single exit, ptr=2, timeout_err unchanged.
